// File: rtl/switch_connection_controller.sv
// Per-output connection sequencer for the 8x8 switch. Turns registered
// arbiter grants into held crossbar connections and steers per-beat flow
// control between the connected input/output pair. Each output also pulses
// ack (and abort on timeout) back to the arbiter when its connection ends.
module switch_connection_controller #(
  parameter int N_PORTS   = 8,
  parameter int MAX_BEATS = 64,
  parameter int TIMEOUT   = 255
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [N_PORTS-1:0]                   grant_valid,
  input  logic [$clog2(N_PORTS+1)*N_PORTS-1:0] grant_port,
  input  logic [N_PORTS-1:0]                   in_valid,
  input  logic [N_PORTS-1:0]                   in_last,
  output logic [N_PORTS-1:0]                   in_ready,
  input  logic [N_PORTS-1:0]                   out_ready,
  output logic [N_PORTS-1:0]                   out_valid,
  output logic [$clog2(N_PORTS)*N_PORTS-1:0]   xbar_sel,
  output logic [N_PORTS-1:0]                   xbar_en,
  output logic [N_PORTS-1:0]                   ack,
  output logic [N_PORTS-1:0]                   abort,
  output logic [15:0]                          abort_count
);

  localparam int CW = $clog2(N_PORTS + 1);   // grant port code width
  localparam int SW = $clog2(N_PORTS);       // crossbar select width
  localparam int BW = $clog2(MAX_BEATS + 1); // beat counter width
  localparam int IW = $clog2(TIMEOUT + 1);   // idle counter width
  localparam int AW = $clog2(N_PORTS + 1);   // per-cycle abort tally width

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_RELEASE
  } state_t;

  state_t            state    [N_PORTS];
  logic [SW-1:0]     sel_q    [N_PORTS];
  logic [BW-1:0]     beat_cnt [N_PORTS];
  logic [IW-1:0]     idle_cnt [N_PORTS];
  logic [N_PORTS-1:0] en_q;
  logic [N_PORTS-1:0] ack_q;
  logic [N_PORTS-1:0] abort_q;

  logic [N_PORTS-1:0] bound;
  logic [N_PORTS-1:0] cand_found;
  logic [SW-1:0]      cand_idx [N_PORTS];
  logic [N_PORTS-1:0] beat;
  logic [N_PORTS-1:0] src_last;
  logic [N_PORTS-1:0] done_beat;
  logic [N_PORTS-1:0] time_out;
  logic [AW-1:0]      n_abort;
  logic [16:0]        abort_sum;

  // Inputs currently held by an active connection
  always_comb begin
    bound = '0;
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      if (state[o] == ST_ACTIVE) bound[sel_q[o]] = 1'b1;
    end
  end

  // Per output: lowest-index free input whose grant names this output
  always_comb begin
    logic found;
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      found       = 1'b0;
      cand_idx[o] = '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        if (!found && grant_valid[i] && (i != o) && !bound[i] &&
            (grant_port[i*CW +: CW] == CW'(o + 1))) begin
          found       = 1'b1;
          cand_idx[o] = SW'(i);
        end
      end
      cand_found[o] = found;
    end
  end

  // Beat handshake steering between connected input and output
  always_comb begin
    in_ready  = '0;
    out_valid = '0;
    beat      = '0;
    src_last  = '0;
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      if (state[o] == ST_ACTIVE) begin
        out_valid[o] = in_valid[sel_q[o]];
        src_last[o]  = in_last[sel_q[o]];
        beat[o]      = in_valid[sel_q[o]] & out_ready[o];
        if (out_ready[o]) in_ready[sel_q[o]] = 1'b1;
      end
    end
  end

  // Packet-end and timeout detection, plus saturating abort tally
  always_comb begin
    done_beat = '0;
    time_out  = '0;
    n_abort   = '0;
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      done_beat[o] = beat[o] & (src_last[o] | (beat_cnt[o] == BW'(MAX_BEATS - 1)));
      time_out[o]  = (state[o] == ST_ACTIVE) & ~beat[o] &
                     (idle_cnt[o] == IW'(TIMEOUT - 1));
      n_abort      = n_abort + AW'(time_out[o]);
    end
    abort_sum = {1'b0, abort_count} + 17'(n_abort);
  end

  // Per-output connection FSMs and the shared abort counter
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned o = 0; o < N_PORTS; o++) begin
        state[o]    <= ST_IDLE;
        sel_q[o]    <= '0;
        beat_cnt[o] <= '0;
        idle_cnt[o] <= '0;
      end
      en_q        <= '0;
      ack_q       <= '0;
      abort_q     <= '0;
      abort_count <= '0;
    end else begin
      abort_count <= abort_sum[16] ? 16'hFFFF : abort_sum[15:0];
      for (int unsigned o = 0; o < N_PORTS; o++) begin
        case (state[o])
          ST_IDLE: begin
            ack_q[o]   <= 1'b0;
            abort_q[o] <= 1'b0;
            if (cand_found[o]) begin
              state[o]    <= ST_ACTIVE;
              en_q[o]     <= 1'b1;
              sel_q[o]    <= cand_idx[o];
              beat_cnt[o] <= '0;
              idle_cnt[o] <= '0;
            end
          end
          ST_ACTIVE: begin
            if (done_beat[o]) begin
              state[o] <= ST_RELEASE;
              en_q[o]  <= 1'b0;
              ack_q[o] <= 1'b1;
            end else if (time_out[o]) begin
              state[o]   <= ST_RELEASE;
              en_q[o]    <= 1'b0;
              ack_q[o]   <= 1'b1;
              abort_q[o] <= 1'b1;
            end else if (beat[o]) begin
              beat_cnt[o] <= beat_cnt[o] + 1'b1;
              idle_cnt[o] <= '0;
            end else begin
              idle_cnt[o] <= idle_cnt[o] + 1'b1;
            end
          end
          ST_RELEASE: begin
            state[o]   <= ST_IDLE;
            ack_q[o]   <= 1'b0;
            abort_q[o] <= 1'b0;
          end
          default: begin
            state[o]   <= ST_IDLE;
            en_q[o]    <= 1'b0;
            ack_q[o]   <= 1'b0;
            abort_q[o] <= 1'b0;
          end
        endcase
      end
    end
  end

  // Flatten per-output selects onto the crossbar bus
  always_comb begin
    xbar_sel = '0;
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      xbar_sel[o*SW +: SW] = sel_q[o];
    end
  end

  assign xbar_en = en_q;
  assign ack     = ack_q;
  assign abort   = abort_q;

endmodule
